tx_clone_scheduler: RTL and testbench
=====================================

# tx_clone_scheduler

Parametrised scheduler for redundant Ethernet transmission: paces frames at a programmable interval and launches each frame as N back-to-back clones with programmable spacing, over a start/busy handshake with `byte_data`. It supplies the frame counter, 1-based clone index and wrapped payload start address for each clone. It also detects and counts frame ticks missed because the previous frame was still sending. It sits in the `clk125MHz` domain between the switch-decode logic and `byte_data`.

## Interface
- `CNT_W`, 27, width of frame-interval counter/`period`
- `GAP_W`, 17, width of clone-gap counter/`gap`
- `COPY_W`, 3, width of `copies`/`clone_idx`
- `ADDR_W`, 20, width of payload addresses
- `ID_W`, 16, width of `frame_id`
- `ADDR_LIMIT`, 57600, address at/after which start address wraps to 0
- `clk`  in  1  transmit clock (125 MHz)
- `rstb`  in  1  reset; synchronous, active-high
- `enable`  in  1  1 = generate new frames
- `period`  in  CNT_W  frame interval minus 1 (cycles)
- `gap`  in  GAP_W  minimum clone spacing term (see Timing)
- `copies`  in  COPY_W  clones per frame; 0 treated as 1
- `busy`  in  1  frame builder busy
- `last_addr`  in  ADDR_W  next unread payload address from frame builder
- `start`  out  1  one-cycle launch pulse to frame builder
- `start_addr`  out  ADDR_W  payload start address for current frame
- `clone_idx`  out  COPY_W  1-based index of clone being launched
- `frame_id`  out  ID_W  current frame number
- `frame_active`  out  1  frame has clones still to launch
- `overrun`  out  1  one-cycle pulse: tick dropped
- `overrun_count`  out  16  saturating dropped-tick count

## Operation
- Reset values: all outputs 0; period counter 0; state IDLE.
- Period counter: free-running 0..`period` while `enable`=1, held at 0 while `enable`=0. Tick = cycle where counter==`period`; counter returns to 0 next cycle. Rate independent of send duration.
- Accepted tick (state IDLE): latch `copies` (0→1) as `n`; `frame_id` += 1 (wraps mod 2^ID_W; first frame is 1); `start_addr` ← (`last_addr` ≥ ADDR_LIMIT) ? 0 : `last_addr`; go to ARM.
- Tick while not IDLE: ignored; `overrun` pulses one cycle; `overrun_count` += 1, saturates at 0xFFFF.
- States: IDLE → ARM (on tick) ; ARM → when `busy`=0: register `start`=1, `clone_idx`+=1 (from 0), go GAP if `clone_idx`<`n` else IDLE ; GAP → gap counter from 0, +1 per cycle; when gap counter==`gap` and `busy`=0, launch next clone as in ARM.
- `clone_idx` holds value after last launch until next frame's first launch, which sets it to 1.
- `frame_active` = state ≠ IDLE (registered; high from cycle after tick through last `start` cycle inclusive).
- `period`, `gap`, `enable` changes take effect immediately; `copies` only at next tick; `gap` compared live.
- `enable`→0 mid-frame: current frame finishes all clones; no new ticks.
- `rstb` mid-frame: next cycle all state/outputs at reset values, `start` low; no partial clones resumed.
- `busy` never high → scheduler never stalls; `busy` stuck high → ARM/GAP wait indefinitely, ticks counted as overruns.

## Timing
- Tick in cycle T with `busy`=0 in T → `start` high in T+1 with `clone_idx`=1, new `frame_id`/`start_addr` valid in T+1.
- Clone k launched in S → earliest clone k+1 in S+`gap`+2; `busy` sampled in S+`gap`+1 (and each later cycle while waiting).
- `start` never high two consecutive cycles; `start_addr`/`frame_id` stable for whole frame.
- Frame interval `period`+1 cycles when no overrun.
- All outputs registered; no combinational path input→output.

## Test plan
- `period`=99, `gap`=9, `copies`=3, `busy`=0 → starts at T+1, T+12, T+23 with `clone_idx` 1,2,3, `frame_id`=1; next frame start at T+101, `frame_id`=2, no overrun.
- `copies`=0 → exactly one `start` per frame, `clone_idx`=1, `frame_active` high one cycle.
- `busy` high cycles T..T+49 around first clone → `start` at T+51, later clones spaced ≥ `gap`+2 from it and only while `busy`=0.
- `period`=19, `gap`=9, `copies`=3 → second tick falls mid-frame: `overrun` pulse, `overrun_count`=1, no extra `start`; frame_id increments every other tick.
- `last_addr`=57600 at tick → `start_addr`=0; `last_addr`=57599 → `start_addr`=57599.
- `rstb` pulsed between clone 1 and 2 → no further `start`, all outputs 0 next cycle; after release first frame has `frame_id`=1.

Source files
------------

// File: rtl/tx_clone_scheduler.sv
// Frame pacing and clone-launch scheduler for redundant Ethernet transmission.
// Each frame tick is turned into N spaced start pulses toward byte_data. Ticks
// that arrive while a frame is still sending are dropped and counted.
module tx_clone_scheduler #(
  parameter int CNT_W      = 27,
  parameter int GAP_W      = 17,
  parameter int COPY_W     = 3,
  parameter int ADDR_W     = 20,
  parameter int ID_W       = 16,
  parameter int ADDR_LIMIT = 57600
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  input  logic [GAP_W-1:0]  gap,
  input  logic [COPY_W-1:0] copies,
  input  logic              busy,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              start,
  output logic [ADDR_W-1:0] start_addr,
  output logic [COPY_W-1:0] clone_idx,
  output logic [ID_W-1:0]   frame_id,
  output logic              frame_active,
  output logic              overrun,
  output logic [15:0]       overrun_count
);

  typedef enum logic [1:0] {IDLE, ARM, GAP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [COPY_W-1:0] n_q, n_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [COPY_W-1:0] clone_idx_q, clone_idx_d;
  logic [ID_W-1:0]   frame_id_q, frame_id_d;
  logic              frame_active_q, frame_active_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       overrun_count_q, overrun_count_d;

  logic              tick;
  logic              accept;
  logic              launch;
  logic              launch_ok;
  logic [COPY_W-1:0] copies_nz;
  logic [COPY_W-1:0] n_eff;
  logic [COPY_W-1:0] clone_cur;

  // Period counter and the shared launch qualifiers. A launch is never allowed
  // in the cycle start is already high, so start cannot pulse back-to-back.
  always_comb begin
    tick      = enable && (cnt_q >= period);
    cnt_d     = (!enable || tick) ? '0 : cnt_q + CNT_W'(1);
    gap_cnt_d = start_q ? '0 : ((&gap_cnt_q) ? gap_cnt_q : gap_cnt_q + GAP_W'(1));
    accept    = tick && (state_q == IDLE);
    launch_ok = !busy && !start_q;
    copies_nz = (copies == '0) ? COPY_W'(1) : copies;
    n_eff     = accept ? copies_nz : n_q;
    clone_cur = (state_q == GAP) ? clone_idx_q + COPY_W'(1) : COPY_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order. Reset here is
  // synchronous: rstb is only seen at a clock edge.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      gap_cnt_q       <= '0;
      n_q             <= '0;
      start_q         <= 1'b0;
      start_addr_q    <= '0;
      clone_idx_q     <= '0;
      frame_id_q      <= '0;
      frame_active_q  <= 1'b0;
      overrun_q       <= 1'b0;
      overrun_count_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      gap_cnt_q       <= gap_cnt_d;
      n_q             <= n_d;
      start_q         <= start_d;
      start_addr_q    <= start_addr_d;
      clone_idx_q     <= clone_idx_d;
      frame_id_q      <= frame_id_d;
      frame_active_q  <= frame_active_d;
      overrun_q       <= overrun_d;
      overrun_count_q <= overrun_count_d;
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (launch_ok) launch  = 1'b1;
          else           state_d = ARM;
        end
      end
      ARM:  if (launch_ok) launch = 1'b1;
      GAP:  if (launch_ok && (gap_cnt_q >= gap)) launch = 1'b1;
      default: state_d = IDLE;
    endcase
    if (launch) state_d = (clone_cur < n_eff) ? GAP : IDLE;
  end

  // Registered outputs; frame_active covers the cycle of the final start.
  always_comb begin
    start_d         = launch;
    n_d             = n_eff;
    clone_idx_d     = launch ? clone_cur : clone_idx_q;
    frame_id_d      = accept ? frame_id_q + ID_W'(1) : frame_id_q;
    start_addr_d    = start_addr_q;
    if (accept)
      start_addr_d  = (last_addr >= ADDR_W'(ADDR_LIMIT)) ? '0 : last_addr;
    frame_active_d  = (state_d != IDLE) || launch;
    overrun_d       = tick && (state_q != IDLE);
    overrun_count_d = overrun_count_q;
    if (overrun_d && (overrun_count_q != 16'hFFFF))
      overrun_count_d = overrun_count_q + 16'd1;
  end

  assign start         = start_q;
  assign start_addr    = start_addr_q;
  assign clone_idx     = clone_idx_q;
  assign frame_id      = frame_id_q;
  assign frame_active  = frame_active_q;
  assign overrun       = overrun_q;
  assign overrun_count = overrun_count_q;

endmodule

// File: tb/tb_tx_clone_scheduler.sv
// Self-checking bench for tx_clone_scheduler: a time-based reference model of
// frames, clone spacing and dropped ticks is compared against the DUT every cycle.
module tb_tx_clone_scheduler;

  localparam int CNT_W  = 27;
  localparam int GAP_W  = 17;
  localparam int COPY_W = 3;
  localparam int ADDR_W = 20;
  localparam int ID_W   = 16;
  localparam int LIMIT  = 57600;

  logic              clk;
  logic              rstb;
  logic              enable;
  logic [CNT_W-1:0]  period;
  logic [GAP_W-1:0]  gap;
  logic [COPY_W-1:0] copies;
  logic              busy;
  logic [ADDR_W-1:0] last_addr;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [COPY_W-1:0] clone_idx;
  logic [ID_W-1:0]   frame_id;
  logic              frame_active;
  logic              overrun;
  logic [15:0]       overrun_count;

  int checks = 0;
  int errors = 0;

  tx_clone_scheduler dut (
    .clk          (clk),
    .rstb         (rstb),
    .enable       (enable),
    .period       (period),
    .gap          (gap),
    .copies       (copies),
    .busy         (busy),
    .last_addr    (last_addr),
    .start        (start),
    .start_addr   (start_addr),
    .clone_idx    (clone_idx),
    .frame_id     (frame_id),
    .frame_active (frame_active),
    .overrun      (overrun),
    .overrun_count(overrun_count)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // Reference model: a frame is a number of clones still owed; a clone may go
  // out once the previous start is at least gap+2 cycles back.
  int              pcnt;
  bit              active;
  int              n_clones;
  int              sent;
  longint          cyc;
  longint          last_start;
  logic            m_start;
  logic            m_ovr;
  logic            m_act;
  logic [COPY_W-1:0] m_clone;
  logic [ID_W-1:0]   m_fid;
  logic [15:0]       m_ovc;
  logic [ADDR_W-1:0] m_addr;
  int              starts_seen;

  task automatic model_cycle();
    bit tick;
    bit go;
    m_start = 1'b0;
    m_ovr   = 1'b0;
    if (rstb) begin
      pcnt = 0; active = 0; sent = 0; n_clones = 0; last_start = -100;
      m_clone = '0; m_fid = '0; m_addr = '0; m_act = 1'b0; m_ovc = '0;
    end else begin
      tick = enable && (pcnt == int'(period));
      pcnt = (!enable || tick) ? 0 : pcnt + 1;
      if (tick) begin
        if (active) begin
          m_ovr = 1'b1;
          if (m_ovc != 16'hFFFF) m_ovc = m_ovc + 16'd1;
        end else begin
          active   = 1;
          n_clones = (copies == '0) ? 1 : int'(copies);
          sent     = 0;
          m_fid    = m_fid + ID_W'(1);
          m_addr   = (int'(last_addr) >= LIMIT) ? '0 : last_addr;
        end
      end
      go = active && !busy && (cyc != last_start) &&
           (sent == 0 || (cyc - last_start - 1) >= longint'(gap));
      if (go) begin
        sent++;
        m_clone    = COPY_W'(sent);
        last_start = cyc + 1;
        if (sent == n_clones) active = 0;
      end
      m_start = go;
      m_act   = active || go;
    end
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
    if (m_start) starts_seen++;
    check("start",         32'(start),         32'(m_start));
    check("clone_idx",     32'(clone_idx),     32'(m_clone));
    check("frame_id",      32'(frame_id),      32'(m_fid));
    check("start_addr",    32'(start_addr),    32'(m_addr));
    check("frame_active",  32'(frame_active),  32'(m_act));
    check("overrun",       32'(overrun),       32'(m_ovr));
    check("overrun_count", 32'(overrun_count), 32'(m_ovc));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic configure(input int p, input int g, input int c);
    enable = 1'b0;
    step();
    period = CNT_W'(p);
    gap    = GAP_W'(g);
    copies = COPY_W'(c);
    enable = 1'b1;
  endtask

  initial begin
    cyc = 0; last_start = -100; starts_seen = 0;
    rstb = 1'b1; enable = 1'b0; period = '0; gap = '0; copies = '0;
    busy = 1'b0; last_addr = '0;
    run(2);
    rstb = 1'b0;

    // Nominal three-clone frames; first address at the wrap limit.
    last_addr = ADDR_W'(57600);
    configure(99, 9, 3);
    run(230);

    // Single clone per frame with copies=0, address just below the limit.
    last_addr = ADDR_W'(57599);
    configure(99, 9, 0);
    run(220);

    // busy held high for 50 cycles starting on the tick cycle.
    last_addr = ADDR_W'(1234);
    configure(99, 9, 3);
    for (int i = 0; i < 200 && pcnt != int'(period); i++) step();
    busy = 1'b1;
    run(50);
    busy = 1'b0;
    run(80);

    // Ticks landing inside a frame are dropped.
    configure(19, 9, 3);
    run(200);

    // Reset between clone 1 and clone 2, then restart from frame 1.
    configure(99, 9, 3);
    for (int i = 0; i < 300 && !(active && sent == 1); i++) step();
    run(3);
    rstb = 1'b1;
    step();
    rstb = 1'b0;
    run(130);

    // Randomized configurations and handshake behaviour.
    for (int k = 0; k < 8; k++) begin
      configure(int'($urandom_range(0, 40)), int'($urandom_range(0, 10)),
                int'($urandom_range(0, 7)));
      for (int i = 0; i < 400; i++) begin
        busy = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 199) == 0) enable = ~enable;
        if ($urandom_range(0, 49) == 0) copies = COPY_W'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       last_addr = ADDR_W'(57600);
          1:       last_addr = ADDR_W'(57599);
          default: last_addr = ADDR_W'($urandom_range(0, 2 ** ADDR_W - 1));
        endcase
        step();
      end
    end
    busy = 1'b0;

    // Stuck busy with a tick every cycle drives the overrun count to saturation.
    configure(0, 3, 2);
    busy = 1'b1;
    run(65545);
    busy = 1'b0;
    run(10);

    check("starts_total_nonzero", 32'(starts_seen > 20), 32'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
